// File: rtl/branch_pc_if.sv
// Decoder/pipeline-facing bundle of the branch/PC unit: decoded control and
// comparator flags in; PC, redirect, trap and statistics out.
interface branch_pc_if;
  logic        inst_valid;
  logic        inst_ready;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [2:0]  funct3;
  logic        BrEq;
  logic        BrLT;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        illegal_br;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic        trap_ack;
  logic [15:0] br_cnt;
  logic [15:0] taken_cnt;

  // Pipeline side: presents instructions and acknowledges traps.
  modport master (
    output inst_valid, is_branch, is_jal, is_jalr, funct3, BrEq, BrLT,
           imm, rs1_data, trap_ack,
    input  inst_ready, pc, pc_plus4, flush, illegal_br, misalign,
           misalign_addr, br_cnt, taken_cnt
  );

  // Branch/PC unit side.
  modport slave (
    input  inst_valid, is_branch, is_jal, is_jalr, funct3, BrEq, BrLT,
           imm, rs1_data, trap_ack,
    output inst_ready, pc, pc_plus4, flush, illegal_br, misalign,
           misalign_addr, br_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_pc_unit.sv
// RV32I program counter and branch resolution: resolves B-type/JAL/JALR,
// redirects with a one-cycle flush, traps on misaligned targets, counts branches.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  branch_pc_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic        inst_ready_q;
  logic        flush_q;
  logic        illegal_br_q;
  logic        misalign_q;
  logic [31:0] misalign_addr_q;
  logic [15:0] br_cnt_q;
  logic [15:0] taken_cnt_q;

  logic        accept;
  logic        is_ctrl;
  logic        taken;
  logic        illegal;
  logic [31:0] target;
  logic [31:0] jalr_sum;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept   = bus.inst_valid & inst_ready_q;
  assign is_ctrl  = bus.is_branch | bus.is_jal | bus.is_jalr;
  assign jalr_sum = bus.rs1_data + bus.imm;

  // Decode priority: JALR over JAL over B-type.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    taken   = 1'b0;
    illegal = 1'b0;
    target  = pc_q + bus.imm;
    if (bus.is_jalr) begin
      taken  = 1'b1;
      target = jalr_sum & ~32'h1;
    end else if (bus.is_jal) begin
      taken  = 1'b1;
    end else if (bus.is_branch) begin
      unique case (bus.funct3)
        3'b000:          taken = bus.BrEq;
        3'b001:          taken = ~bus.BrEq;
        3'b100, 3'b110:  taken = bus.BrLT;
        3'b101, 3'b111:  taken = ~bus.BrLT;
        3'b010, 3'b011:  illegal = 1'b1;
        default:         taken = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pc_q            <= RESET_PC;
      inst_ready_q    <= 1'b0;
      flush_q         <= 1'b0;
      illegal_br_q    <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'h0;
      br_cnt_q        <= 16'h0;
      taken_cnt_q     <= 16'h0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values; blocking here would create order-dependent races.
      flush_q      <= 1'b0;
      illegal_br_q <= 1'b0;
      unique case (state)
        IDLE: begin
          state        <= RUN;
          inst_ready_q <= 1'b1;
        end
        RUN: begin
          if (accept) begin
            if (is_ctrl) br_cnt_q <= sat_inc(br_cnt_q);
            illegal_br_q <= illegal;
            if (taken && target[1:0] == 2'b00) begin
              pc_q        <= target;
              flush_q     <= 1'b1;
              taken_cnt_q <= sat_inc(taken_cnt_q);
            end else if (taken) begin
              // Misaligned target: hold pc, stop accepting, report address.
              misalign_addr_q <= target;
              misalign_q      <= 1'b1;
              inst_ready_q    <= 1'b0;
              state           <= TRAP;
            end else begin
              pc_q <= pc_q + 32'd4;
            end
          end
        end
        TRAP: begin
          if (bus.trap_ack) begin
            pc_q         <= TRAP_VEC;
            flush_q      <= 1'b1;
            misalign_q   <= 1'b0;
            inst_ready_q <= 1'b1;
            state        <= RUN;
          end
        end
        default: begin
          state        <= IDLE;
          inst_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_q + 32'd4;
  assign bus.inst_ready    = inst_ready_q;
  assign bus.flush         = flush_q;
  assign bus.illegal_br    = illegal_br_q;
  assign bus.misalign      = misalign_q;
  assign bus.misalign_addr = misalign_addr_q;
  assign bus.br_cnt        = br_cnt_q;
  assign bus.taken_cnt     = taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: fetch, branch table, JALR alignment,
// trap entry/exit, reset mid-trap, decode priority and counter saturation.
module tb_branch_pc_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   exp_br = 0;
  int   exp_taken = 0;

  branch_pc_if bif ();

  branch_pc_unit #(.RESET_PC(32'h0), .TRAP_VEC(32'h100)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.inst_valid = 1'b0;
    bif.is_branch  = 1'b0;
    bif.is_jal     = 1'b0;
    bif.is_jalr    = 1'b0;
    bif.funct3     = 3'd0;
    bif.BrEq       = 1'b0;
    bif.BrLT       = 1'b0;
    bif.imm        = 32'h0;
    bif.rs1_data   = 32'h0;
    bif.trap_ack   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    tests++;
    if (bif.pc !== 32'h0 || bif.flush !== 1'b0 || bif.illegal_br !== 1'b0 ||
        bif.misalign !== 1'b0 || bif.misalign_addr !== 32'h0 ||
        bif.br_cnt !== 16'h0 || bif.taken_cnt !== 16'h0 || bif.inst_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s reset values: pc=%h flush=%b ill=%b mis=%b maddr=%h br=%h tk=%h rdy=%b, want all zero",
               tag, bif.pc, bif.flush, bif.illegal_br, bif.misalign, bif.misalign_addr,
               bif.br_cnt, bif.taken_cnt, bif.inst_ready);
    end
  endtask

  task automatic check_counts(input string tag);
    tests++;
    if (bif.br_cnt !== 16'(exp_br) || bif.taken_cnt !== 16'(exp_taken)) begin
      fails++;
      $display("FAIL %s counters: br=%0d taken=%0d, want br=%0d taken=%0d",
               tag, bif.br_cnt, bif.taken_cnt, exp_br, exp_taken);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    tests++;
    if (bif.inst_ready !== 1'b0) begin
      fails++; $display("FAIL idle_ready got %b want 0", bif.inst_ready);
    end
    step();
    tests++;
    if (bif.inst_ready !== 1'b1) begin
      fails++; $display("FAIL run_ready got %b want 1", bif.inst_ready);
    end
    exp_br = 0; exp_taken = 0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    bif.inst_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bif.pc !== exp_pc[i] || bif.flush !== 1'b0 || bif.pc_plus4 !== exp_pc[i] + 32'd4) begin
        fails++;
        $display("FAIL seq_pc[%0d] pc=%h flush=%b pc4=%h, want pc=%h flush=0",
                 i, bif.pc, bif.flush, bif.pc_plus4, exp_pc[i]);
      end
    end
    bif.inst_valid = 1'b0;
    check_counts("seq");
  endtask

  task automatic jalr_to_100();
    clear_inputs();
    bif.inst_valid = 1'b1;
    bif.is_jalr    = 1'b1;
    bif.rs1_data   = 32'h100;
    step();
    exp_br++; exp_taken++;
  endtask

  task automatic test_branch_table();
    logic tk;
    logic [31:0] want_pc;
    for (int f = 0; f < 8; f++) begin
      for (int e = 0; e < 2; e++) begin
        for (int l = 0; l < 2; l++) begin
          jalr_to_100();
          tests++;
          if (bif.pc !== 32'h100) begin
            fails++; $display("FAIL tbl_setup pc=%h want 00000100", bif.pc);
          end
          case (f)
            0:       tk = 1'(e);
            1:       tk = ~1'(e);
            4, 6:    tk = 1'(l);
            5, 7:    tk = ~1'(l);
            default: tk = 1'b0;
          endcase
          want_pc = tk ? 32'h120 : 32'h104;
          bif.is_jalr   = 1'b0;
          bif.is_branch = 1'b1;
          bif.funct3    = 3'(f);
          bif.BrEq      = 1'(e);
          bif.BrLT      = 1'(l);
          bif.imm       = 32'h20;
          step();
          exp_br++;
          if (tk) exp_taken++;
          tests++;
          if (bif.pc !== want_pc || bif.flush !== tk ||
              bif.illegal_br !== (f == 2 || f == 3)) begin
            fails++;
            $display("FAIL tbl f3=%0d eq=%0d lt=%0d pc=%h flush=%b ill=%b, want pc=%h flush=%b ill=%b",
                     f, e, l, bif.pc, bif.flush, bif.illegal_br, want_pc, tk, (f == 2 || f == 3));
          end
          check_counts("tbl");
        end
      end
    end
    clear_inputs();
    step();
    tests++;
    if (bif.illegal_br !== 1'b0 || bif.flush !== 1'b0) begin
      fails++; $display("FAIL tbl_pulse_end ill=%b flush=%b want 0 0", bif.illegal_br, bif.flush);
    end
  endtask

  task automatic test_jalr_align();
    clear_inputs();
    bif.inst_valid = 1'b1;
    bif.is_jalr    = 1'b1;
    bif.rs1_data   = 32'h1001;
    bif.imm        = 32'h4;
    step();
    exp_br++; exp_taken++;
    tests++;
    if (bif.pc !== 32'h1004 || bif.flush !== 1'b1) begin
      fails++; $display("FAIL jalr_clear pc=%h flush=%b want 00001004 1", bif.pc, bif.flush);
    end
    bif.inst_valid = 1'b0;
    step();
    tests++;
    if (bif.flush !== 1'b0) begin
      fails++; $display("FAIL jalr_flush_one got %b want 0", bif.flush);
    end
    bif.inst_valid = 1'b1;
    bif.rs1_data   = 32'h1002;
    bif.imm        = 32'h0;
    step();
    exp_br++;
    tests++;
    if (bif.misalign !== 1'b1 || bif.misalign_addr !== 32'h1002 || bif.pc !== 32'h1004 ||
        bif.inst_ready !== 1'b0 || bif.flush !== 1'b0) begin
      fails++;
      $display("FAIL jalr_trap mis=%b maddr=%h pc=%h rdy=%b flush=%b, want 1 00001002 00001004 0 0",
               bif.misalign, bif.misalign_addr, bif.pc, bif.inst_ready, bif.flush);
    end
    check_counts("jalr_trap");
  endtask

  task automatic test_trap_exit();
    clear_inputs();
    bif.inst_valid = 1'b1;
    bif.is_jal     = 1'b1;
    bif.imm        = 32'h8;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bif.pc !== 32'h1004 || bif.misalign !== 1'b1 || bif.flush !== 1'b0) begin
        fails++;
        $display("FAIL trap_hold[%0d] pc=%h mis=%b flush=%b want 00001004 1 0",
                 i, bif.pc, bif.misalign, bif.flush);
      end
    end
    check_counts("trap_hold");
    clear_inputs();
    bif.trap_ack = 1'b1;
    step();
    bif.trap_ack = 1'b0;
    tests++;
    if (bif.pc !== 32'h100 || bif.flush !== 1'b1 || bif.misalign !== 1'b0 ||
        bif.inst_ready !== 1'b1 || bif.misalign_addr !== 32'h1002) begin
      fails++;
      $display("FAIL trap_ack pc=%h flush=%b mis=%b rdy=%b maddr=%h want 00000100 1 0 1 00001002",
               bif.pc, bif.flush, bif.misalign, bif.inst_ready, bif.misalign_addr);
    end
    bif.trap_ack = 1'b1;
    step();
    bif.trap_ack = 1'b0;
    tests++;
    if (bif.pc !== 32'h100 || bif.flush !== 1'b0 || bif.misalign !== 1'b0 || bif.inst_ready !== 1'b1) begin
      fails++;
      $display("FAIL ack_in_run pc=%h flush=%b mis=%b rdy=%b want 00000100 0 0 1",
               bif.pc, bif.flush, bif.misalign, bif.inst_ready);
    end
    check_counts("trap_exit");
  endtask

  task automatic test_priority();
    clear_inputs();
    bif.inst_valid = 1'b1;
    bif.is_branch  = 1'b1;
    bif.is_jal     = 1'b1;
    bif.is_jalr    = 1'b1;
    bif.funct3     = 3'b010;
    bif.rs1_data   = 32'h200;
    bif.imm        = 32'h10;
    step();
    exp_br++; exp_taken++;
    tests++;
    if (bif.pc !== 32'h210 || bif.illegal_br !== 1'b0 || bif.flush !== 1'b1) begin
      fails++;
      $display("FAIL prio_jalr pc=%h ill=%b flush=%b want 00000210 0 1", bif.pc, bif.illegal_br, bif.flush);
    end
    bif.is_jalr = 1'b0;
    bif.funct3  = 3'b000;
    bif.BrEq    = 1'b0;
    step();
    exp_br++; exp_taken++;
    tests++;
    if (bif.pc !== 32'h220 || bif.flush !== 1'b1) begin
      fails++; $display("FAIL prio_jal pc=%h flush=%b want 00000220 1", bif.pc, bif.flush);
    end
    check_counts("prio");
  endtask

  task automatic test_reset_mid_trap();
    clear_inputs();
    bif.inst_valid = 1'b1;
    bif.is_jal     = 1'b1;
    bif.imm        = 32'h2;
    step();
    clear_inputs();
    tests++;
    if (bif.misalign !== 1'b1 || bif.misalign_addr !== 32'h222) begin
      fails++; $display("FAIL jal_trap mis=%b maddr=%h want 1 00000222", bif.misalign, bif.misalign_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("mid_trap");
    rst_n = 1'b1;
    step();
    tests++;
    if (bif.inst_ready !== 1'b1 || bif.pc !== 32'h0) begin
      fails++; $display("FAIL post_reset rdy=%b pc=%h want 1 00000000", bif.inst_ready, bif.pc);
    end
    exp_br = 0; exp_taken = 0;
  endtask

  task automatic test_saturation();
    clear_inputs();
    bif.inst_valid = 1'b1;
    bif.is_jal     = 1'b1;
    bif.imm        = 32'h4;
    for (int i = 0; i < 65534; i++) step();
    tests++;
    if (bif.br_cnt !== 16'hFFFE || bif.taken_cnt !== 16'hFFFE) begin
      fails++; $display("FAIL sat_pre br=%h tk=%h want fffe fffe", bif.br_cnt, bif.taken_cnt);
    end
    for (int i = 0; i < 6; i++) step();
    clear_inputs();
    tests++;
    if (bif.br_cnt !== 16'hFFFF || bif.taken_cnt !== 16'hFFFF || bif.pc !== 32'h0004_0010) begin
      fails++;
      $display("FAIL sat br=%h tk=%h pc=%h want ffff ffff 00040010", bif.br_cnt, bif.taken_cnt, bif.pc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_table();
    test_jalr_align();
    test_trap_exit();
    test_priority();
    test_reset_mid_trap();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
